// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel-request coordinates run LOOKAHEAD ce-cycles
// ahead of de/hsync/vsync so the pixel pipeline can cover its latency.
module video_timing_gen #(
    parameter int H_ACTIVE  = 32'd640,
    parameter int H_FP      = 32'd16,
    parameter int H_SYNC    = 32'd96,
    parameter int H_BP      = 32'd48,
    parameter int V_ACTIVE  = 32'd480,
    parameter int V_FP      = 32'd10,
    parameter int V_SYNC    = 32'd2,
    parameter int V_BP      = 32'd33,
    parameter bit HS_POL    = 1'b1,
    parameter bit VS_POL    = 1'b1,
    parameter int LOOKAHEAD = 32'd2,
    parameter int CW        = 32'd12
) (
    input  logic          pixclk,
    input  logic          rst_n,
    input  logic          ce,
    output logic          req_o,
    output logic [CW-1:0] x_o,
    output logic [CW-1:0] y_o,
    output logic          line_start_o,
    output logic          frame_start_o,
    output logic [15:0]   frame_cnt_o,
    output logic          de_o,
    output logic          hsync_o,
    output logic          vsync_o
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Thresholds kept 32 bits wide so an end-of-sync equal to the total never overflows CW.
    localparam logic [31:0] H_ACT_END = 32'(H_ACTIVE);
    localparam logic [31:0] H_SYN_BEG = 32'(H_ACTIVE + H_FP);
    localparam logic [31:0] H_SYN_END = 32'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [31:0] V_ACT_END = 32'(V_ACTIVE);
    localparam logic [31:0] V_SYN_BEG = 32'(V_ACTIVE + V_FP);
    localparam logic [31:0] V_SYN_END = 32'(V_ACTIVE + V_FP + V_SYNC);

    localparam int DE_B = 2;
    localparam int HS_B = 1;
    localparam int VS_B = 0;

    if ((LOOKAHEAD < 0) || (LOOKAHEAD > 7)) begin : g_bad_lookahead
        $error("video_timing_gen: LOOKAHEAD must be within 0..7");
    end
    if ((((H_TOT - 1) >> CW) != 0) || (((V_TOT - 1) >> CW) != 0)) begin : g_bad_cw
        $error("video_timing_gen: CW too narrow for H_TOT-1 / V_TOT-1");
    end

    logic [CW-1:0] h_cnt_r;
    logic [CW-1:0] v_cnt_r;
    logic          h_last_s;
    logic          v_last_s;
    logic [31:0]   h_wide_s;
    logic [31:0]   v_wide_s;
    logic          req_s;
    logic          hs_s;
    logic          vs_s;

    // dly_r[0] is the stage-0 copy; dly_r[LOOKAHEAD] drives the encoder outputs.
    logic [2:0]    dly_r [LOOKAHEAD+1];

    assign h_last_s = (h_cnt_r == CW'(H_TOT - 1));
    assign v_last_s = (v_cnt_r == CW'(V_TOT - 1));

    // Raster position and completed-frame counters.
    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_r     <= '0;
            v_cnt_r     <= '0;
            frame_cnt_o <= 16'd0;
        end else if (ce) begin
            if (h_last_s) begin
                h_cnt_r <= '0;
                if (v_last_s) begin
                    v_cnt_r     <= '0;
                    frame_cnt_o <= frame_cnt_o + 16'd1;
                end else begin
                    v_cnt_r <= v_cnt_r + CW'(1);
                end
            end else begin
                h_cnt_r <= h_cnt_r + CW'(1);
            end
        end
    end

    // Region decode of the current position.
    always_comb begin
        h_wide_s = 32'(h_cnt_r);
        v_wide_s = 32'(v_cnt_r);
        req_s    = 1'b0;
        hs_s     = 1'b0;
        vs_s     = 1'b0;
        if ((h_wide_s < H_ACT_END) && (v_wide_s < V_ACT_END)) begin
            req_s = 1'b1;
        end else begin
            req_s = 1'b0;
        end
        if ((h_wide_s >= H_SYN_BEG) && (h_wide_s < H_SYN_END)) begin
            hs_s = 1'b1;
        end else begin
            hs_s = 1'b0;
        end
        if ((v_wide_s >= V_SYN_BEG) && (v_wide_s < V_SYN_END)) begin
            vs_s = 1'b1;
        end else begin
            vs_s = 1'b0;
        end
    end

    // Stage-0 request outputs plus the ce-gated de/hs/vs delay line.
    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            req_o         <= 1'b0;
            x_o           <= '0;
            y_o           <= '0;
            line_start_o  <= 1'b0;
            frame_start_o <= 1'b0;
            for (int i = 0; i <= LOOKAHEAD; i++) begin
                dly_r[i] <= 3'b000;
            end
        end else if (ce) begin
            req_o         <= req_s;
            x_o           <= h_cnt_r;
            y_o           <= v_cnt_r;
            line_start_o  <= (h_cnt_r == '0);
            frame_start_o <= (h_cnt_r == '0) && (v_cnt_r == '0);
            dly_r[0]      <= {req_s, hs_s, vs_s};
            for (int i = 1; i <= LOOKAHEAD; i++) begin
                dly_r[i] <= dly_r[i-1];
            end
        end
    end

    assign de_o    = dly_r[LOOKAHEAD][DE_B];
    assign hsync_o = dly_r[LOOKAHEAD][HS_B] ? HS_POL : ~HS_POL;
    assign vsync_o = dly_r[LOOKAHEAD][VS_B] ? VS_POL : ~VS_POL;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a shrunken raster driven with ce patterns and
// compared against a linear-pixel-index model; a second instance covers
// inverted polarity with zero lookahead.
module tb_video_timing_gen;

    localparam int HA = 16, HFP = 4, HSW = 6, HBP = 5;
    localparam int VA = 10, VFP = 2, VSW = 3, VBP = 4;
    localparam int H_TOT = HA + HFP + HSW + HBP;
    localparam int V_TOT = VA + VFP + VSW + VBP;
    localparam int TOT   = H_TOT * V_TOT;
    localparam int LA    = 2;
    localparam int CW    = 8;

    logic pixclk = 1'b0;
    logic rst_n  = 1'b0;
    logic ce     = 1'b0;

    always #5 pixclk = ~pixclk;

    logic          req_a, ls_a, fs_a, de_a, hs_a, vs_a;
    logic [CW-1:0] x_a, y_a;
    logic [15:0]   fc_a;
    logic          req_b, ls_b, fs_b, de_b, hs_b, vs_b;
    logic [CW-1:0] x_b, y_b;
    logic [15:0]   fc_b;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HS_POL(1'b1), .VS_POL(1'b1), .LOOKAHEAD(LA), .CW(CW)
    ) dut_a (
        .pixclk(pixclk), .rst_n(rst_n), .ce(ce),
        .req_o(req_a), .x_o(x_a), .y_o(y_a),
        .line_start_o(ls_a), .frame_start_o(fs_a), .frame_cnt_o(fc_a),
        .de_o(de_a), .hsync_o(hs_a), .vsync_o(vs_a)
    );

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HS_POL(1'b0), .VS_POL(1'b0), .LOOKAHEAD(0), .CW(CW)
    ) dut_b (
        .pixclk(pixclk), .rst_n(rst_n), .ce(ce),
        .req_o(req_b), .x_o(x_b), .y_o(y_b),
        .line_start_o(ls_b), .frame_start_o(fs_b), .frame_cnt_o(fc_b),
        .de_o(de_b), .hsync_o(hs_b), .vsync_o(vs_b)
    );

    wire [37:0] obs_a = {req_a, x_a, y_a, ls_a, fs_a, fc_a, de_a, hs_a, vs_a};
    wire [37:0] obs_b = {req_b, x_b, y_b, ls_b, fs_b, fc_b, de_b, hs_b, vs_b};

    int checks = 0;
    int passes = 0;

    // Model: next pixel index to be presented, plus what each ce edge presented.
    int          pos;
    logic        m_req, m_ls, m_fs;
    logic [7:0]  m_x, m_y;
    logic [15:0] m_frames;
    logic [2:0]  hist [0:2];

    task automatic model_reset();
        pos = 0; m_frames = 16'd0;
        m_req = 1'b0; m_ls = 1'b0; m_fs = 1'b0; m_x = 8'd0; m_y = 8'd0;
        for (int i = 0; i < 3; i++) hist[i] = 3'b000;
    endtask

    task automatic model_step();
        int x, y;
        logic hs, vs;
        x = pos % H_TOT;
        y = pos / H_TOT;
        m_req = (x < HA) && (y < VA);
        m_x = 8'(x);
        m_y = 8'(y);
        m_ls = (x == 0);
        m_fs = (pos == 0);
        hs = (x >= HA + HFP) && (x < HA + HFP + HSW);
        vs = (y >= VA + VFP) && (y < VA + VFP + VSW);
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = {m_req, hs, vs};
        pos = pos + 1;
        if (pos == TOT) begin
            pos = 0;
            m_frames = m_frames + 16'd1;
        end
    endtask

    function automatic logic [37:0] exp_a();
        return {m_req, m_x, m_y, m_ls, m_fs, m_frames, hist[LA][2], hist[LA][1], hist[LA][0]};
    endfunction

    function automatic logic [37:0] exp_b();
        return {m_req, m_x, m_y, m_ls, m_fs, m_frames, hist[0][2], ~hist[0][1], ~hist[0][0]};
    endfunction

    task automatic tick(input logic c);
        ce = c;
        @(posedge pixclk);
        if (rst_n && c) model_step();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) tick(1'b1);
        checks++;
        if ({obs_a, obs_b} !== {exp_a(), exp_b()})
            $display("FAIL reset: got %h/%h exp %h/%h", obs_a, obs_b, exp_a(), exp_b());
        else passes++;
    endtask

    task automatic test_startup();
        rst_n = 1'b1;
        tick(1'b1);
        checks++;
        if ({req_a, x_a, y_a, fs_a, de_a} !== {1'b1, 8'd0, 8'd0, 1'b1, 1'b0})
            $display("FAIL edge1: got req=%b x=%0d y=%0d fs=%b de=%b exp 1 0 0 1 0",
                     req_a, x_a, y_a, fs_a, de_a);
        else passes++;
        tick(1'b1);
        checks++;
        if (de_a !== 1'b0) $display("FAIL edge2_de: got %b exp 0", de_a);
        else passes++;
        tick(1'b1);
        checks++;
        if (de_a !== 1'b1) $display("FAIL edge3_de: got %b exp 1", de_a);
        else passes++;
        checks++;
        if ({obs_a, obs_b} !== {exp_a(), exp_b()})
            $display("FAIL startup_model: got %h/%h exp %h/%h", obs_a, obs_b, exp_a(), exp_b());
        else passes++;
    endtask

    task automatic test_line();
        int de_run = 0, hs_run = 0, since_ls = 0, last_ls = -1;
        bit de_seen = 0, hs_seen = 0, ls_seen = 0;
        logic prev_de, prev_hs;
        for (int c = 0; c < 3 * H_TOT; c++) begin
            prev_de = de_a; prev_hs = hs_a;
            tick(1'b1);
            checks++;
            if ({obs_a, obs_b} !== {exp_a(), exp_b()})
                $display("FAIL line_model: got %h/%h exp %h/%h", obs_a, obs_b, exp_a(), exp_b());
            else passes++;
            since_ls++;
            if (ls_a) begin
                if (last_ls >= 0) begin
                    checks++;
                    if (c - last_ls != H_TOT) $display("FAIL line_period: got %0d exp %0d", c - last_ls, H_TOT);
                    else passes++;
                end
                last_ls = c; since_ls = 0; ls_seen = 1;
            end
            if (hs_a && !prev_hs) begin
                hs_seen = 1; hs_run = 0;
                if (ls_seen) begin
                    checks++;
                    if (since_ls != HA + HFP + LA)
                        $display("FAIL hsync_offset: got %0d exp %0d", since_ls, HA + HFP + LA);
                    else passes++;
                end
            end
            if (hs_a) hs_run++;
            else if (prev_hs && hs_seen) begin
                checks++;
                if (hs_run != HSW) $display("FAIL hsync_width: got %0d exp %0d", hs_run, HSW);
                else passes++;
            end
            if (de_a && !prev_de) begin de_seen = 1; de_run = 0; end
            if (de_a) de_run++;
            else if (prev_de && de_seen) begin
                checks++;
                if (de_run != HA) $display("FAIL de_width: got %0d exp %0d", de_run, HA);
                else passes++;
            end
        end
    endtask

    task automatic test_frames();
        int last_fs = -1, vs_run = 0;
        bit vs_seen = 0;
        logic prev_vs;
        logic [CW-1:0] prev_y;
        for (int c = 0; c < 2 * TOT + H_TOT; c++) begin
            prev_vs = vs_a; prev_y = y_a;
            tick(1'b1);
            checks++;
            if ({obs_a, obs_b} !== {exp_a(), exp_b()})
                $display("FAIL frame_model: got %h/%h exp %h/%h", obs_a, obs_b, exp_a(), exp_b());
            else passes++;
            if (fs_a) begin
                if (last_fs >= 0) begin
                    checks++;
                    if (c - last_fs != TOT) $display("FAIL frame_period: got %0d exp %0d", c - last_fs, TOT);
                    else passes++;
                end
                last_fs = c;
            end
            if (vs_a && !prev_vs) begin vs_seen = 1; vs_run = 0; end
            if (vs_a) vs_run++;
            else if (prev_vs && vs_seen) begin
                checks++;
                if (vs_run != VSW * H_TOT) $display("FAIL vsync_width: got %0d exp %0d", vs_run, VSW * H_TOT);
                else passes++;
            end
            if ((y_a == 8'd0) && (prev_y != 8'd0)) begin
                checks++;
                if (prev_y != 8'(V_TOT - 1)) $display("FAIL y_wrap: got %0d exp %0d", prev_y, V_TOT - 1);
                else passes++;
            end
        end
    endtask

    task automatic test_ce_hold();
        int budget = 2 * TOT;
        while ((x_a != 8'd10) && (budget > 0)) begin
            tick(1'b1);
            budget--;
        end
        checks++;
        if (x_a != 8'd10) $display("FAIL ce_hold_wait: got x=%0d exp 10", x_a);
        else passes++;
        for (int i = 0; i < 10; i++) begin
            tick(1'b0);
            checks++;
            if (({obs_a, obs_b} !== {exp_a(), exp_b()}) || (x_a !== 8'd10))
                $display("FAIL ce_hold_frozen: got %h/%h exp %h/%h", obs_a, obs_b, exp_a(), exp_b());
            else passes++;
        end
        tick(1'b1);
        checks++;
        if (x_a !== 8'd11) $display("FAIL ce_resume: got x=%0d exp 11", x_a);
        else passes++;
    endtask

    task automatic test_random_ce();
        for (int c = 0; c < 1500; c++) begin
            tick(($urandom % 4) != 0);
            checks++;
            if ({obs_a, obs_b} !== {exp_a(), exp_b()})
                $display("FAIL random_model: got %h/%h exp %h/%h", obs_a, obs_b, exp_a(), exp_b());
            else passes++;
            checks++;
            if (de_b !== req_b) $display("FAIL la0_de_eq_req: got de=%b exp %b", de_b, req_b);
            else passes++;
        end
    endtask

    task automatic test_async_reset();
        int budget = 2 * TOT;
        while (!((x_a == 8'd28) && (y_a == 8'd13)) && (budget > 0)) begin
            tick(1'b1);
            budget--;
        end
        checks++;
        if ({x_a, y_a, vs_a, hs_b} !== {8'd28, 8'd13, 1'b1, 1'b1})
            $display("FAIL async_pre: got x=%0d y=%0d vs=%b hs_b=%b exp 28 13 1 1", x_a, y_a, vs_a, hs_b);
        else passes++;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({de_a, hs_a, vs_a, fc_a, hs_b, vs_b} !== {1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1})
            $display("FAIL async_reset: got de=%b hs=%b vs=%b fc=%0d hs_b=%b vs_b=%b exp 0 0 0 0 1 1",
                     de_a, hs_a, vs_a, fc_a, hs_b, vs_b);
        else passes++;
        checks++;
        if ({obs_a, obs_b} !== {exp_a(), exp_b()})
            $display("FAIL async_model: got %h/%h exp %h/%h", obs_a, obs_b, exp_a(), exp_b());
        else passes++;
        tick(1'b1);
        rst_n = 1'b1;
        for (int c = 0; c < 2 * H_TOT; c++) begin
            tick(1'b1);
            checks++;
            if ({obs_a, obs_b} !== {exp_a(), exp_b()})
                $display("FAIL post_reset_model: got %h/%h exp %h/%h", obs_a, obs_b, exp_a(), exp_b());
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_line();
        test_frames();
        test_ce_hold();
        test_random_ce();
        test_async_reset();
        test_random_ce();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
